// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALU op codes, MIPS opcode/funct
// constants, and the payload carried from decode to the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_XOR  = 4'h2;
    localparam logic [3:0] ALU_NOR  = 4'h3;
    localparam logic [3:0] ALU_ADDU = 4'h4;
    localparam logic [3:0] ALU_SUBU = 4'h5;
    localparam logic [3:0] ALU_ADD  = 4'h6;
    localparam logic [3:0] ALU_SUB  = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SLLV = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;
    localparam logic [3:0] ALU_SRLV = 4'hB;
    localparam logic [3:0] ALU_SLT  = 4'hC;
    localparam logic [3:0] ALU_SLTU = 4'hD;
    localparam logic [3:0] ALU_CLO  = 4'hE;
    localparam logic [3:0] ALU_CLZ  = 4'hF;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_CLZ  = 6'h20;
    localparam logic [5:0] FN_CLO  = 6'h21;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode to ALU op code plus operand selection.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        illegal
);

    always_comb begin
        op      = ALU_AND;
        a       = rs_val;
        b       = rt_val;
        illegal = 1'b0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_XOR:  op = ALU_XOR;
                FN_NOR:  op = ALU_NOR;
                FN_ADDU: op = ALU_ADDU;
                FN_SUBU: op = ALU_SUBU;
                FN_ADD:  op = ALU_ADD;
                FN_SUB:  op = ALU_SUB;
                FN_SLT:  op = ALU_SLT;
                FN_SLTU: op = ALU_SLTU;
                FN_SLL:  begin op = ALU_SLL;  a = rt_val; b = {27'b0, shamt};       end
                FN_SRL:  begin op = ALU_SRL;  a = rt_val; b = {27'b0, shamt};       end
                FN_SLLV: begin op = ALU_SLLV; a = rt_val; b = {27'b0, rs_val[4:0]}; end
                FN_SRLV: begin op = ALU_SRLV; a = rt_val; b = {27'b0, rs_val[4:0]}; end
                default: illegal = 1'b1;
            endcase
        end else if (opcode == OPC_SPECIAL2) begin
            case (funct)
                FN_CLO:  begin op = ALU_CLO; b = '0; end
                FN_CLZ:  begin op = ALU_CLZ; b = '0; end
                default: illegal = 1'b1;
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_operand_issue.sv
// Issue stage in front of the ALU: decode, output register plus one skid
// entry behind a registered in_ready, and a saturating illegal-op counter.
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] illegal_count
);

    alu_issue_t       dec, out_q, out_d, skid_q, skid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
    logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic             dec_illegal, acc, push, out_free;

    alu_op_decode u_dec (
        .opcode  (in_opcode),
        .funct   (in_funct),
        .shamt   (in_shamt),
        .rs_val  (in_rs_val),
        .rt_val  (in_rt_val),
        .op      (dec.op),
        .a       (dec.a),
        .b       (dec.b),
        .illegal (dec_illegal)
    );

    assign acc      = in_valid & in_ready;
    assign push     = acc & ~dec_illegal;
    assign out_free = ~out_vld_q | out_ready;

    // in_ready high implies the skid is empty, so push never meets a full skid.
    always_comb begin
        out_d      = out_q;
        out_tag_d  = out_tag_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_tag_d = skid_tag_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_tag_d  = skid_tag_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (push) begin
                out_d     = dec;
                out_tag_d = in_tag;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (push) begin
            skid_d     = dec;
            skid_tag_d = in_tag;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= '0;
            out_tag_q     <= '0;
            out_vld_q     <= 1'b0;
            skid_q        <= '0;
            skid_tag_q    <= '0;
            skid_vld_q    <= 1'b0;
            in_ready      <= 1'b1;
            illegal_pulse <= 1'b0;
            illegal_count <= '0;
        end else begin
            out_q         <= out_d;
            out_tag_q     <= out_tag_d;
            out_vld_q     <= out_vld_d;
            skid_q        <= skid_d;
            skid_tag_q    <= skid_tag_d;
            skid_vld_q    <= skid_vld_d;
            in_ready      <= ~skid_vld_d;
            illegal_pulse <= acc & dec_illegal & ~flush;
            if (acc && dec_illegal && !flush && illegal_count != {CNT_W{1'b1}})
                illegal_count <= illegal_count + 1'b1;
        end
    end

    assign out_valid = out_vld_q;
    assign out_op    = out_q.op;
    assign out_a     = out_q.a;
    assign out_b     = out_q.b;
    assign out_tag   = out_tag_q;

endmodule
